// File: rtl/mac_bfm_pkg.sv
// rtl/mac_bfm_pkg.sv - shared constants and types for the MAC receive-side BFM
// Holds the frame generator FSM encoding, the fixed frame bytes, the CRC-32
// constants and the PRBS-8 generator definition used by generator and checker.
package mac_bfm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY_REF  = 32'hEDB8_8320;

    // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci LFSR: feedback is the
    // parity of state bits 7,5,4,3 shifted into bit 0.
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    localparam logic [7:0]  LFSR_SEED     = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide reflected Ethernet CRC-32 register
// Ports: i_clk/i_rst (async active-high), i_init reloads CRC_INIT,
// i_en folds i_data into the state, o_crc is the raw (uncomplemented) state.
// Running it over data plus transmitted FCS leaves CRC_RESIDUE.
module crc32_d8
    import mac_bfm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_next;

    // LSB-first bit-serial division unrolled over one byte.
    always_comb begin
        w_next = r_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_next = w_next[0] ? ((w_next >> 1) ^ CRC_POLY_REF) : (w_next >> 1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc <= CRC_INIT;
        end else if (i_init) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= w_next;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/mii_frame_gen.sv
// rtl/mii_frame_gen.sv - MII/GMII receive-pin Ethernet frame generator
// Inputs: Rx_clk, reset (async active-high), start, mode (1=GMII 0=MII),
//         frm_len, pattern_sel (0=incrementing 1=PRBS-8), err_inject.
// Outputs: busy, done (pulse at first IFG cycle), frm_cnt, Rx_dv, Rx_er, Rxd.
// Frame: preamble, SFD, payload, complemented CRC-32 LSB first, then IFG.
module mii_frame_gen
    import mac_bfm_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_MIN      = 12,
    parameter int MAX_LEN      = 1518
)
(
    input  logic        Rx_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] frm_len,
    input  logic        pattern_sel,
    input  logic        err_inject,
    output logic        busy,
    output logic        done,
    output logic [15:0] frm_cnt,
    output logic        Rx_dv,
    output logic        Rx_er,
    output logic [7:0]  Rxd
);

    localparam int IFG_W = $clog2(IFG_MIN + 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_mode;
    logic               r_pat;
    logic               r_err;
    logic [15:0]        r_len;
    logic [15:0]        r_idx;
    logic               r_ph;
    logic [IFG_W-1:0]   r_ifg;
    logic [7:0]         r_lfsr;
    logic [15:0]        r_frm_cnt;

    logic               w_byte_end;
    logic [7:0]         w_byte;
    logic               w_dv;
    logic [31:0]        w_crc;
    logic [7:0]         w_fcs_byte;

    // A byte-time ends every cycle in GMII, on the high-nibble cycle in MII.
    assign w_byte_end = r_mode | r_ph;

    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_idx[1:0])
            2'd0:    w_fcs_byte = ~w_crc[7:0];
            2'd1:    w_fcs_byte = ~w_crc[15:8];
            2'd2:    w_fcs_byte = ~w_crc[23:16];
            default: w_fcs_byte = ~w_crc[31:24];
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_byte = 8'h00;
        w_dv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && frm_len != 16'd0) w_next = ST_PRE;
            end
            ST_PRE: begin
                w_dv   = 1'b1;
                w_byte = PREAMBLE_BYTE;
                if (w_byte_end && r_idx == 16'(PREAMBLE_LEN - 1)) w_next = ST_SFD;
            end
            ST_SFD: begin
                w_dv   = 1'b1;
                w_byte = SFD_BYTE;
                if (w_byte_end) w_next = ST_DATA;
            end
            ST_DATA: begin
                w_dv   = 1'b1;
                w_byte = r_pat ? r_lfsr : r_idx[7:0];
                if (w_byte_end && r_idx == r_len - 16'd1) w_next = ST_FCS;
            end
            ST_FCS: begin
                w_dv   = 1'b1;
                w_byte = w_fcs_byte;
                if (w_byte_end && r_idx == 16'd3) w_next = ST_IFG;
            end
            ST_IFG: begin
                if (w_byte_end && r_ifg == IFG_W'(IFG_MIN - 1)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Rx_clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_pat     <= 1'b0;
            r_err     <= 1'b0;
            r_len     <= 16'd0;
            r_idx     <= 16'd0;
            r_ph      <= 1'b0;
            r_ifg     <= '0;
            r_lfsr    <= LFSR_SEED;
            r_frm_cnt <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                r_ph  <= 1'b0;
                r_idx <= 16'd0;
                r_ifg <= '0;
                if (w_next == ST_PRE) begin
                    r_mode <= mode;
                    r_pat  <= pattern_sel;
                    r_err  <= err_inject;
                    r_len  <= (frm_len > 16'(MAX_LEN)) ? 16'(MAX_LEN) : frm_len;
                    r_lfsr <= LFSR_SEED;
                end
            end else begin
                r_ph <= r_mode ? 1'b0 : ~r_ph;
                if (w_byte_end) begin
                    // Byte index restarts at every state boundary.
                    r_idx <= (w_next != r_state) ? 16'd0 : r_idx + 16'd1;
                    if (r_state == ST_DATA) r_lfsr <= lfsr_next(r_lfsr);
                    if (r_state == ST_IFG)  r_ifg  <= r_ifg + IFG_W'(1);
                    if (r_state == ST_FCS && w_next == ST_IFG) begin
                        r_frm_cnt <= r_frm_cnt + 16'd1;
                    end
                end
            end
        end
    end

    crc32_d8 u_crc (
        .i_clk  (Rx_clk),
        .i_rst  (reset),
        .i_init (r_state == ST_IDLE),
        .i_en   (r_state == ST_DATA && w_byte_end),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_IFG) && (r_ifg == '0) && !r_ph;
    assign frm_cnt = r_frm_cnt;
    assign Rx_dv   = w_dv;
    assign Rx_er   = (r_state == ST_DATA) && r_err && (r_idx == (r_len >> 1));
    assign Rxd     = r_mode ? w_byte : {4'h0, (r_ph ? w_byte[7:4] : w_byte[3:0])};

endmodule

// File: tb/tb_mii_frame_gen.sv
// tb/tb_mii_frame_gen.sv - self-checking bench for mii_frame_gen
module tb_mii_frame_gen;

    localparam int PRE_N = 7;
    localparam int IFG_N = 12;
    localparam int MAXL  = 1518;

    logic        Rx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b1;
    logic [15:0] frm_len = 16'd0;
    logic        pattern_sel = 1'b0;
    logic        err_inject = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] frm_cnt;
    logic        Rx_dv;
    logic        Rx_er;
    logic [7:0]  Rxd;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 Rx_clk = ~Rx_clk;

    mii_frame_gen #(.PREAMBLE_LEN(PRE_N), .IFG_MIN(IFG_N), .MAX_LEN(MAXL)) dut (
        .Rx_clk      (Rx_clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .frm_len     (frm_len),
        .pattern_sel (pattern_sel),
        .err_inject  (err_inject),
        .busy        (busy),
        .done        (done),
        .frm_cnt     (frm_cnt),
        .Rx_dv       (Rx_dv),
        .Rx_er       (Rx_er),
        .Rxd         (Rxd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++) begin
            if (x[0] ^ b[i]) x = (x >> 1) ^ 32'hEDB88320;
            else             x = x >> 1;
        end
        return x;
    endfunction

    // One frame: model the byte sequence, drive a request, capture every cycle
    // until busy drops, then compare cycle by cycle.
    task automatic run_frame(input logic m, input int len, input logic p, input logic e);
        logic [7:0] exp_b[$];
        logic [7:0] cap_b[$];
        logic [7:0] c_rxd[$];
        logic       c_dv[$];
        logic       c_er[$];
        logic       c_done[$];
        logic [15:0] c_cnt[$];
        logic [7:0] lf;
        logic [7:0] d;
        logic [7:0] eb;
        logic [7:0] erx;
        logic [31:0] crc;
        int eff, bt, nb, cyc, err_idx;
        int n_rxd, n_dv, n_er, n_done, er_hi, done_hi;

        eff = (len > MAXL) ? MAXL : len;
        bt  = m ? 1 : 2;
        for (int i = 0; i < PRE_N; i++) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        lf  = 8'h01;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < eff; k++) begin
            d = p ? lf : 8'(k);
            exp_b.push_back(d);
            crc = crc_byte(crc, d);
            lf  = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) exp_b.push_back(crc[8*i +: 8]);
        nb = exp_b.size();
        err_idx = PRE_N + 1 + eff / 2;

        @(negedge Rx_clk);
        start = 1'b1; mode = m; frm_len = 16'(len); pattern_sel = p; err_inject = e;
        @(negedge Rx_clk);
        start = 1'b0;
        // Scramble the request fields; the frame in flight must not notice.
        mode = ~m; frm_len = 16'($urandom); pattern_sel = ~p; err_inject = ~e;
        cyc = 0;
        while (busy && cyc < 5000) begin
            c_rxd.push_back(Rxd); c_dv.push_back(Rx_dv); c_er.push_back(Rx_er);
            c_done.push_back(done); c_cnt.push_back(frm_cnt);
            start = (cyc == 3);
            @(negedge Rx_clk);
            cyc++;
        end
        start = 1'b0;
        check("busy_bounded", 32'(cyc < 5000), 32'd1);
        check("busy_cycles", 32'(cyc), 32'((nb + IFG_N) * bt));

        n_rxd = 0; n_dv = 0; n_er = 0; n_done = 0; er_hi = 0; done_hi = 0;
        for (int i = 0; i < cyc; i++) begin
            logic xdv;
            xdv = (i < nb * bt);
            if (xdv) begin
                eb  = exp_b[i / bt];
                erx = m ? eb : {4'h0, ((i % 2) ? eb[7:4] : eb[3:0])};
            end else begin
                erx = 8'h00;
            end
            if (c_rxd[i] !== erx) n_rxd++;
            if (c_dv[i] !== xdv) n_dv++;
            if (c_er[i] !== (e && xdv && (i / bt == err_idx))) n_er++;
            if (c_done[i] !== (i == nb * bt)) n_done++;
            if (c_er[i] === 1'b1) er_hi++;
            if (c_done[i] === 1'b1) done_hi++;
            if (c_done[i] === 1'b1) check("cnt_at_done", 32'(c_cnt[i]), 32'(16'(exp_cnt + 1)));
            if (i < nb * bt && (m || (i % 2) == 1)) begin
                cap_b.push_back(m ? c_rxd[i] : {c_rxd[i][3:0], c_rxd[i-1][3:0]});
            end
        end
        check("rxd_stream", 32'(n_rxd), 32'd0);
        check("dv_stream", 32'(n_dv), 32'd0);
        check("er_stream", 32'(n_er), 32'd0);
        check("er_cycles", 32'(er_hi), e ? 32'(bt) : 32'd0);
        check("done_stream", 32'(n_done), 32'd0);
        check("done_pulses", 32'(done_hi), 32'd1);

        crc = 32'hFFFFFFFF;
        for (int i = PRE_N + 1; i < cap_b.size(); i++) crc = crc_byte(crc, cap_b[i]);
        check("crc_residue", crc, 32'hDEBB20E3);
        if (p && cap_b.size() > PRE_N + 1) check("prbs_first", 32'(cap_b[PRE_N + 1]), 32'h01);

        exp_cnt = exp_cnt + 1;
        check("frm_cnt", 32'(frm_cnt), 32'(16'(exp_cnt)));
    endtask

    task automatic run_back_to_back();
        int cyc, dones, low, gaps;
        logic prev_dv, seen_fall;
        @(negedge Rx_clk);
        start = 1'b1; mode = 1'b1; frm_len = 16'd64; pattern_sel = 1'b0; err_inject = 1'b0;
        cyc = 0; dones = 0; low = 0; gaps = 0; prev_dv = 1'b0; seen_fall = 1'b0;
        while (dones < 3 && cyc < 1000) begin
            @(negedge Rx_clk);
            cyc++;
            if (prev_dv && !Rx_dv) begin seen_fall = 1'b1; low = 0; end
            if (!Rx_dv) low++;
            if (!prev_dv && Rx_dv && seen_fall) begin
                gaps++;
                check("b2b_gap", 32'(low), 32'd13);
            end
            if (done) begin
                dones++;
                exp_cnt = exp_cnt + 1;
                check("b2b_cnt", 32'(frm_cnt), 32'(16'(exp_cnt)));
                if (dones == 3) start = 1'b0;
            end
            prev_dv = Rx_dv;
        end
        check("b2b_bounded", 32'(cyc < 1000), 32'd1);
        check("b2b_gaps", 32'(gaps), 32'd2);
        cyc = 0;
        while (busy && cyc < 100) begin @(negedge Rx_clk); cyc++; end
        repeat (3) @(negedge Rx_clk);
        check("b2b_no_extra", {15'h0, busy, frm_cnt}, {16'h0, 16'(exp_cnt)});
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge Rx_clk);
        check("reset_outs", {12'h0, busy, done, Rx_dv, Rx_er, Rxd, frm_cnt}, 32'h0);
        reset = 1'b0;

        run_frame(1'b1, 60, 1'b0, 1'b0);
        run_frame(1'b0, 1, 1'b0, 1'b0);
        run_frame(1'b1, 10, 1'b0, 1'b1);
        run_frame(1'b0, 10, 1'b0, 1'b1);

        // Zero length request is ignored.
        @(negedge Rx_clk);
        start = 1'b1; frm_len = 16'd0; mode = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge Rx_clk);
            if (busy || Rx_dv) seen++;
        end
        start = 1'b0;
        check("zero_len_ignored", 32'(seen), 32'd0);

        run_back_to_back();
        run_frame(1'b1, 2000, 1'b1, 1'b0);
        run_frame(1'b0, 5, 1'b1, 1'b1);

        for (int t = 0; t < 6; t++) begin
            run_frame(1'($urandom), int'($urandom_range(1, 80)), 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of payload byte 20.
        @(negedge Rx_clk);
        start = 1'b1; mode = 1'b1; frm_len = 16'd60; pattern_sel = 1'b0; err_inject = 1'b0;
        @(negedge Rx_clk);
        start = 1'b0;
        repeat (PRE_N + 1 + 20) @(negedge Rx_clk);
        check("pre_reset_byte", {23'h0, Rx_dv, Rxd}, {23'h0, 1'b1, 8'h14});
        reset = 1'b1;
        #1;
        check("reset_mid_frame", {12'h0, busy, done, Rx_dv, Rx_er, Rxd, frm_cnt}, 32'h0);
        exp_cnt = 0;
        @(negedge Rx_clk);
        reset = 1'b0;
        run_frame(1'b1, 60, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
